// File: rtl/mdsa_pkg.sv
// Shared types and helpers for the MDSA shearsort sorter.
// MDSA_INDEX_OUT_EN adds a load-position tag to every matrix cell.
package mdsa_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

`ifdef MDSA_INDEX_OUT_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  // Shearsort needs log2(N)+1 row phases interleaved with log2(N) column phases.
  function automatic int phase_count(input int n);
    return 2 * $clog2(n) + 1;
  endfunction

  // A cell is the key in the top bits, optionally followed by its tag.
  function automatic int cell_width(input int data_w, input int idx_w);
    return data_w + (TAG_EN ? idx_w : 0);
  endfunction

endpackage

// File: rtl/mdsa_cmp_swap.sv
// Combinational compare-exchange of two cells; the key sits in the top DATA_W bits.
// desc_i=1 orders the pair high-then-low; equal keys never swap.
module mdsa_cmp_swap
  import mdsa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4,
  localparam int CELL_W = cell_width(DATA_W, IDX_W)
) (
  input  logic [CELL_W-1:0] a_i,
  input  logic [CELL_W-1:0] b_i,
  input  logic              desc_i,
  output logic [CELL_W-1:0] first_o,
  output logic [CELL_W-1:0] second_o
);

  logic [DATA_W-1:0] a_key;
  logic [DATA_W-1:0] b_key;
  logic              swap;

  assign a_key    = a_i[CELL_W-1 -: DATA_W];
  assign b_key    = b_i[CELL_W-1 -: DATA_W];
  assign swap     = desc_i ? (a_key < b_key) : (a_key > b_key);
  assign first_o  = swap ? b_i : a_i;
  assign second_o = swap ? a_i : b_i;

endmodule

// File: rtl/mdsa_shear_sorter.sv
// N x N shearsort: serial row-major load, PH*N in-place compare-exchange steps, snake-order stream out.
// Define MDSA_INDEX_OUT_EN to carry load positions through the sort and expose them on index_out.
module mdsa_shear_sorter
  import mdsa_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  localparam int IDX_W = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              descending,
  input  logic [DATA_W-1:0] data_in,
  output logic              rdy,
  output logic              busy,
  output logic              output_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              done
`ifdef MDSA_INDEX_OUT_EN
  , output logic [IDX_W-1:0] index_out
`endif
);

  localparam int CELLS  = N * N;
  localparam int LOGN   = $clog2(N);
  localparam int HALF   = N / 2;
  localparam int PH     = phase_count(N);
  localparam int PH_W   = $clog2(PH);
  localparam int CELL_W = cell_width(DATA_W, IDX_W);

  state_t              state_q;
  logic                start_q, desc_q;
  logic [IDX_W-1:0]    k_q, out_q;
  logic [PH_W-1:0]     phase_q;
  logic [LOGN-1:0]     step_q;
  logic [CELL_W-1:0]   mat_q [CELLS];
  logic [CELL_W-1:0]   mat_d [CELLS];
  logic                oe_q, done_q;
  logic [DATA_W-1:0]   dout_q;
  logic [CELL_W-1:0]   cell_in, cell_sel;
  logic [IDX_W-1:0]    out_addr;
  logic                col_phase, odd_step;

  logic [CELL_W-1:0]   first_w  [N][HALF];
  logic [CELL_W-1:0]   second_w [N][HALF];
  logic [IDX_W-1:0]    pa_w     [N][HALF];
  logic [IDX_W-1:0]    pb_w     [N][HALF];
  logic                pv_w     [N][HALF];

  assign col_phase = phase_q[0];
  assign odd_step  = step_q[0];

  // Lane gi is a row in row phases and a column in column phases; index = {row, col}.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    for (genvar gj = 0; gj < HALF; gj++) begin : g_pair
      localparam logic [LOGN-1:0] LANE = LOGN'(gi);
      localparam logic [LOGN-1:0] C0E  = LOGN'(2 * gj);
      localparam logic [LOGN-1:0] C1E  = LOGN'(2 * gj + 1);
      localparam logic [LOGN-1:0] C0O  = LOGN'(2 * gj + 1);
      localparam logic [LOGN-1:0] C1O  = LOGN'((2 * gj + 2 < N) ? 2 * gj + 2 : 2 * gj + 1);
      localparam bit              LAST = (gj == HALF - 1);
      localparam bit              ODD_LANE = (gi % 2 == 1);

      logic [LOGN-1:0] c0, c1;
      logic            pair_desc;

      assign c0 = odd_step ? C0O : C0E;
      assign c1 = odd_step ? C1O : C1E;
      assign pa_w[gi][gj] = col_phase ? {c0, LANE} : {LANE, c0};
      assign pb_w[gi][gj] = col_phase ? {c1, LANE} : {LANE, c1};
      assign pv_w[gi][gj] = !(odd_step && LAST);
      assign pair_desc    = col_phase ? desc_q : (desc_q ^ ODD_LANE);

      mdsa_cmp_swap #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
        .a_i     (mat_q[pa_w[gi][gj]]),
        .b_i     (mat_q[pb_w[gi][gj]]),
        .desc_i  (pair_desc),
        .first_o (first_w[gi][gj]),
        .second_o(second_w[gi][gj])
      );
    end
  end

  always_comb begin
    mat_d = mat_q;
    for (int l = 0; l < N; l++) begin
      for (int j = 0; j < HALF; j++) begin
        if (pv_w[l][j]) begin
          mat_d[pa_w[l][j]] = first_w[l][j];
          mat_d[pb_w[l][j]] = second_w[l][j];
        end
      end
    end
  end

`ifdef MDSA_INDEX_OUT_EN
  assign cell_in = {data_in, k_q};
`else
  assign cell_in = data_in;
`endif

  // Odd rows are read right-to-left, so the column bits are inverted there.
  assign out_addr = {out_q[IDX_W-1:LOGN],
                     out_q[LOGN] ? ~out_q[LOGN-1:0] : out_q[LOGN-1:0]};
  assign cell_sel = mat_q[out_addr];

`ifdef MDSA_INDEX_OUT_EN
  logic [IDX_W-1:0] idx_q;
  assign index_out = idx_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      desc_q  <= 1'b0;
      k_q     <= '0;
      out_q   <= '0;
      phase_q <= '0;
      step_q  <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
`ifdef MDSA_INDEX_OUT_EN
      idx_q   <= '0;
`endif
      for (int i = 0; i < CELLS; i++) mat_q[i] <= '0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: begin
          if (start && !start_q) begin
            desc_q  <= descending;
            k_q     <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (en) begin
            mat_q[k_q] <= cell_in;
            k_q        <= k_q + 1'b1;
            if (k_q == IDX_W'(CELLS - 1)) begin
              phase_q <= '0;
              step_q  <= '0;
              state_q <= SORT;
            end
          end
        end
        SORT: begin
          mat_q  <= mat_d;
          step_q <= step_q + 1'b1;
          if (&step_q) begin
            phase_q <= phase_q + 1'b1;
            if (phase_q == PH_W'(PH - 1)) begin
              out_q   <= '0;
              state_q <= OUT;
            end
          end
        end
        OUT: begin
          // The cycle after the final element is presented closes the job.
          if (done_q) begin
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
`ifdef MDSA_INDEX_OUT_EN
            idx_q   <= '0;
`endif
            state_q <= IDLE;
          end else begin
            oe_q   <= 1'b1;
            done_q <= (out_q == IDX_W'(CELLS - 1));
            dout_q <= cell_sel[CELL_W-1 -: DATA_W];
`ifdef MDSA_INDEX_OUT_EN
            idx_q  <= cell_sel[IDX_W-1:0];
`endif
            out_q  <= out_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy           = (state_q == IDLE);
  assign busy          = !rdy;
  assign output_enable = oe_q;
  assign data_out      = dout_q;
  assign done          = done_q;

endmodule
